maxpool_window_gen: RTL and testbench

- Streaming producer for the combinational `max_pool2d` block.
- Accepts a raster-order feature-map pixel stream, one pixel per handshake.
- Assembles non-overlapping K×K windows (stride K) and presents each as a flat vector in exactly the packing `max_pool2d` consumes on `in_window_flat`.
- Sits between the convolution output stream and the pooling comparator.

---
 rtl/maxpool_window_gen.sv | 124 ++++++++++++
 tb/tb_maxpool_window_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_window_gen.sv
// Streaming K x K window assembler for max_pool2d: takes a raster pixel stream and
// emits non-overlapping windows, packed with element r*K+c at WIDTH*(r*K+c).
module maxpool_window_gen #(
   parameter int K     = 2,
   parameter int WIDTH = 8,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_pixel,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*K*K-1:0]   out_window_flat,
   output logic                   out_last
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int BW = $clog2(K);

   logic [CW-1:0]          r_col;
   logic [RW-1:0]          r_row;
   logic [BW-1:0]          r_bandCol;
   logic [BW-1:0]          r_bandRow;
   logic                   r_outValid;
   logic                   r_outLast;
   logic [WIDTH*K*K-1:0]   r_outWindow;
   logic [WIDTH-1:0]       r_lineBuf [K-1][IMG_W];
   logic [WIDTH-1:0]       r_lead [K-1];

   logic                   w_inXfer;
   logic                   w_outXfer;
   logic                   w_lastBandRow;
   logic                   w_lastBandCol;
   logic                   w_complete;
   logic                   w_frameEnd;
   logic [CW-1:0]          w_colBase;
   logic [WIDTH*K*K-1:0]   w_window;

   assign in_ready        = !r_outValid || out_ready;
   assign out_valid       = r_outValid;
   assign out_last        = r_outLast;
   assign out_window_flat = r_outWindow;

   assign w_inXfer      = in_valid && in_ready;
   assign w_outXfer     = r_outValid && out_ready;
   assign w_lastBandRow = (r_bandRow == BW'(K-1));
   assign w_lastBandCol = (r_bandCol == BW'(K-1));
   assign w_complete    = w_inXfer && w_lastBandRow && w_lastBandCol;
   assign w_frameEnd    = (r_row == RW'(IMG_H-1)) && (r_col == CW'(IMG_W-1));
   assign w_colBase     = r_col - CW'(K-1);

   // The bottom-right pixel of the window is the one arriving now, so it bypasses storage.
   always_comb begin
      w_window = '0;
      for (int r = 0; r < K-1; r++) begin
         for (int c = 0; c < K; c++) begin
            w_window[WIDTH*(r*K+c) +: WIDTH] = r_lineBuf[r][w_colBase + CW'(c)];
         end
      end
      for (int c = 0; c < K-1; c++) begin
         w_window[WIDTH*((K-1)*K+c) +: WIDTH] = r_lead[c];
      end
      w_window[WIDTH*(K*K-1) +: WIDTH] = in_pixel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col       <= '0;
         r_row       <= '0;
         r_bandCol   <= '0;
         r_bandRow   <= '0;
         r_outValid  <= 1'b0;
         r_outLast   <= 1'b0;
         r_outWindow <= '0;
      end else begin
         if (w_inXfer) begin
            if (r_col == CW'(IMG_W-1)) begin
               r_col     <= '0;
               r_bandCol <= '0;
               if (r_row == RW'(IMG_H-1)) begin
                  r_row     <= '0;
                  r_bandRow <= '0;
               end else begin
                  r_row     <= r_row + RW'(1);
                  r_bandRow <= w_lastBandRow ? '0 : r_bandRow + BW'(1);
               end
            end else begin
               r_col     <= r_col + CW'(1);
               r_bandCol <= w_lastBandCol ? '0 : r_bandCol + BW'(1);
            end
         end
         // A new window takes priority over a pop so back-to-back windows never bubble.
         if (w_complete) begin
            r_outValid  <= 1'b1;
            r_outLast   <= w_frameEnd;
            r_outWindow <= w_window;
         end else if (w_outXfer) begin
            r_outValid  <= 1'b0;
            r_outLast   <= 1'b0;
         end
      end
   end

   // Pixel storage carries no reset; stale contents are always overwritten before use.
   always_ff @(posedge clk) begin
      if (w_inXfer) begin
         for (int r = 0; r < K-1; r++) begin
            if (r_bandRow == BW'(r)) begin
               r_lineBuf[r][r_col] <= in_pixel;
            end
         end
         for (int c = 0; c < K-1; c++) begin
            if (w_lastBandRow && (r_bandCol == BW'(c))) begin
               r_lead[c] <= in_pixel;
            end
         end
      end
   end

endmodule

// File: tb/tb_maxpool_window_gen.sv
// Testbench for maxpool_window_gen: drives a K=2 4x4 and a K=3 6x6 instance and checks
// every emitted window against a frame-array reference model through a scoreboard queue.
module tb_maxpool_window_gen;

   localparam int WIDTH = 8;
   localparam int MAXW  = WIDTH*9;

   typedef struct {
      logic [MAXW-1:0] win;
      logic            last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic inValid;
   logic [WIDTH-1:0] inPixel;
   logic outReady = 1'b1;
   logic sel;
   int   rdyMode;

   logic v2, rdy2, ov2, last2;
   logic [WIDTH*4-1:0] win2;
   logic v3, rdy3, ov3, last3;
   logic [WIDTH*9-1:0] win3;

   logic oValid, oLast, iReady;
   logic [MAXW-1:0] oWin;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;
   int   pos;
   int   curK, curW, curH;
   logic chkLat;
   logic [WIDTH-1:0] frameBuf [0:35];

   always #5 clk = ~clk;

   assign v2 = inValid && !sel;
   assign v3 = inValid && sel;
   assign oValid = sel ? ov3 : ov2;
   assign oLast  = sel ? last3 : last2;
   assign iReady = sel ? rdy3 : rdy2;
   assign oWin   = sel ? win3 : {{(MAXW-WIDTH*4){1'b0}}, win2};

   maxpool_window_gen #(.K(2), .WIDTH(WIDTH), .IMG_W(4), .IMG_H(4)) dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_pixel(inPixel),
      .out_valid(ov2), .out_ready(outReady), .out_window_flat(win2), .out_last(last2)
   );

   maxpool_window_gen #(.K(3), .WIDTH(WIDTH), .IMG_W(6), .IMG_H(6)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_pixel(inPixel),
      .out_valid(ov3), .out_ready(outReady), .out_window_flat(win3), .out_last(last3)
   );

   task automatic checkOutput(input string name, input logic [MAXW-1:0] act, input logic [MAXW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Downstream backpressure: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (rdyMode)
            0:       outReady = 1'b1;
            1:       outReady = 1'($urandom_range(0, 1));
            default: outReady = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every output transfer and polices in_ready and hold.
   initial begin
      logic            holdPending;
      logic [MAXW-1:0] heldWin;
      logic            heldLast;
      exp_t            e;
      holdPending = 1'b0;
      heldWin     = '0;
      heldLast    = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            holdPending = 1'b0;
            chkLat      = 1'b0;
         end else begin
            if (chkLat) begin
               checkOutput("latency_valid", MAXW'(oValid), MAXW'(1));
               chkLat = 1'b0;
            end
            if (holdPending) begin
               checkOutput("hold_window", oWin, heldWin);
               checkOutput("hold_last", MAXW'(oLast), MAXW'(heldLast));
            end
            checkOutput("in_ready", MAXW'(iReady), MAXW'(!oValid || outReady));
            if (oValid && outReady) begin
               if (expQ.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_window actual=%0h required=none", oWin);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("window", oWin, e.win);
                  checkOutput("last", MAXW'(oLast), MAXW'(e.last));
               end
            end
            holdPending = oValid && !outReady;
            heldWin     = oWin;
            heldLast    = oLast;
         end
      end
   end

   task automatic doReset();
      rst     = 1'b1;
      inValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expQ.delete();
      pos    = 0;
      chkLat = 1'b0;
   endtask

   // Offers one pixel until accepted, then records it in the frame model.
   task automatic applyStimulus(input logic [WIDTH-1:0] v);
      logic accepted;
      int   r, c;
      exp_t e;
      inPixel  = v;
      inValid  = 1'b1;
      accepted = 1'b0;
      for (int t = 0; t < 200 && !accepted; t++) begin
         @(negedge clk);
         accepted = iReady;
         @(posedge clk);
         #1;
      end
      inValid = 1'b0;
      if (!accepted) begin
         total++;
         bad++;
         $display("[TB] FAIL accept_timeout actual=0 required=1");
         return;
      end
      r = pos / curW;
      c = pos % curW;
      frameBuf[pos] = v;
      if ((r % curK == curK-1) && (c % curK == curK-1)) begin
         e.win = '0;
         for (int rr = 0; rr < curK; rr++) begin
            for (int cc = 0; cc < curK; cc++) begin
               e.win[WIDTH*(rr*curK+cc) +: WIDTH] = frameBuf[(r-curK+1+rr)*curW + (c-curK+1+cc)];
            end
         end
         e.last = (pos == curW*curH-1);
         expQ.push_back(e);
         chkLat = 1'b1;
      end
      pos = (pos + 1) % (curW*curH);
   endtask

   task automatic feedRaster(input int count);
      for (int i = 0; i < count; i++) applyStimulus(8'(i));
   endtask

   task automatic feedRandom(input int frames, input bit gaps);
      for (int i = 0; i < frames*curW*curH; i++) begin
         applyStimulus(8'($urandom));
         if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain();
      rdyMode = 0;
      for (int t = 0; t < 200 && expQ.size() > 0; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      inValid = 1'b0;
      inPixel = '0;
      rdyMode = 0;
      sel     = 1'b0;
      chkLat  = 1'b0;
      curK = 2; curW = 4; curH = 4;
      doReset();
      checkOutput("reset_valid", MAXW'(oValid), MAXW'(0));
      checkOutput("reset_last", MAXW'(oLast), MAXW'(0));
      checkOutput("reset_window", oWin, MAXW'(0));
      checkOutput("reset_in_ready", MAXW'(iReady), MAXW'(1));

      $display("[TB] raster frame, K=2 4x4");
      feedRaster(16);
      drain();

      $display("[TB] raster frame with 5-cycle stall on first window");
      rdyMode = 2;
      fork
         feedRaster(16);
         begin
            for (int t = 0; t < 100 && !oValid; t++) @(negedge clk);
            repeat (5) @(posedge clk);
            rdyMode = 0;
         end
      join
      drain();

      $display("[TB] signed extremes");
      for (int i = 0; i < 16; i++) applyStimulus((i % 2 == 0) ? 8'h80 : 8'h7F);
      drain();

      $display("[TB] reset mid-frame before any window");
      feedRaster(5);
      doReset();
      checkOutput("abort_valid", MAXW'(oValid), MAXW'(0));
      feedRaster(16);
      drain();

      $display("[TB] reset with a pending window");
      rdyMode = 2;
      feedRaster(6);
      repeat (3) @(posedge clk);
      #1;
      doReset();
      checkOutput("discard_valid", MAXW'(oValid), MAXW'(0));
      checkOutput("discard_last", MAXW'(oLast), MAXW'(0));
      rdyMode = 0;
      feedRaster(16);
      drain();

      $display("[TB] two frames back-to-back");
      feedRaster(16);
      feedRaster(16);
      drain();

      $display("[TB] random data and backpressure, K=2");
      rdyMode = 1;
      feedRandom(3, 1'b1);
      drain();

      $display("[TB] K=3 6x6");
      sel = 1'b1;
      curK = 3; curW = 6; curH = 6;
      doReset();
      checkOutput("reset3_valid", MAXW'(oValid), MAXW'(0));
      feedRaster(36);
      drain();
      rdyMode = 1;
      feedRandom(2, 1'b1);
      drain();

      checkOutput("scoreboard_empty", MAXW'(expQ.size()), MAXW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
